// File: rtl/dmem_pkg.sv
// Shared types and limits for the data memory responder.
package dmem_pkg;

    localparam int unsigned MAX_LATENCY = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Load lane extract/extend and store lane merge for one 32-bit word.
// DATA_MEMORY_ERR_EN: misaligned or reserved-size accesses raise o_err instead of aligning down.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  size_e       i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [31:0] o_rdata,
    output logic [31:0] o_wword,
    output logic [3:0]  o_be,
    output logic        o_err
);

    logic [1:0]  w_off;
    size_e       w_size;
    logic [31:0] w_shifted;

    always_comb begin
        o_err  = 1'b0;
        w_size = i_size;
        w_off  = i_addr_lo;
`ifdef DATA_MEMORY_ERR_EN
        case (i_size)
            SZ_HALF: o_err = i_addr_lo[0];
            SZ_WORD: o_err = |i_addr_lo;
            SZ_RSVD: o_err = 1'b1;
            default: o_err = 1'b0;
        endcase
`else
        // Align down to the access size; the reserved size behaves as a word.
        case (i_size)
            SZ_BYTE: w_off = i_addr_lo;
            SZ_HALF: w_off = {i_addr_lo[1], 1'b0};
            default: begin
                w_size = SZ_WORD;
                w_off  = 2'b00;
            end
        endcase
`endif
    end

    assign w_shifted = i_rword >> {w_off, 3'b000};

    always_comb begin
        o_rdata = '0;
        o_be    = '0;
        o_wword = i_wdata << {w_off, 3'b000};
        case (w_size)
            SZ_BYTE: begin
                o_rdata = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
                o_be    = 4'b0001 << w_off;
            end
            SZ_HALF: begin
                o_rdata = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
                o_be    = 4'b0011 << w_off;
            end
            SZ_WORD: begin
                o_rdata = i_rword;
                o_be    = '1;
            end
            default: ;
        endcase
        if (o_err) begin
            o_rdata = '0;
            o_be    = '0;
        end
    end

endmodule

// File: rtl/data_memory.sv
// Fixed-latency single-port data memory responder for the memory stage.
// DATA_MEMORY_ERR_EN enables access-fault reporting on misaligned/reserved-size requests.
module data_memory
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(MAX_LATENCY);

    state_e           r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt, w_next_cnt;
    logic             r_ready_en;

    logic [1:0]       r_addr_lo;
    logic [AW-1:0]    r_idx;
    size_e            r_size;
    logic             r_we;
    logic             r_unsigned;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rword;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic             w_accept;
    logic             w_commit;
    logic [AW-1:0]    w_req_idx;
    logic [31:0]      w_rdata;
    logic [31:0]      w_wword;
    logic [3:0]       w_be;
    logic             w_err;
    logic             w_unused_addr;

    assign w_req_idx     = req_addr[AW+1:2];
    assign w_unused_addr = ^req_addr[31:AW+2];

    // Ready stays low while reset is held and rises on the first edge after release.
    assign req_ready = (r_state == ST_IDLE) && r_ready_en;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_ready_en <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_next_state = ST_RESP;
                    end else begin
                        w_next_state = ST_WAIT;
                        w_next_cnt   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) w_next_state = ST_RESP;
                else             w_next_cnt   = r_cnt - 1'b1;
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr_lo  <= '0;
            r_idx      <= '0;
            r_size     <= SZ_BYTE;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
        end else if (w_accept) begin
            r_addr_lo  <= req_addr[1:0];
            r_idx      <= w_req_idx;
            r_size     <= size_e'(req_size);
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata;
        end
    end

    dmem_lane_align u_lane_align (
        .i_addr_lo  (r_addr_lo),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rword    (r_rword),
        .o_rdata    (w_rdata),
        .o_wword    (w_wword),
        .o_be       (w_be),
        .o_err      (w_err)
    );

    assign w_commit = (r_state == ST_RESP) && r_we;

    // Read happens on the accept edge; stores land on the RESP edge, so the two never collide.
    always_ff @(posedge clk) begin
        if (w_accept) r_rword <= r_mem[w_req_idx];
        if (w_commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[r_idx][8*i +: 8] <= w_wword[8*i +: 8];
            end
        end
    end

    assign resp_valid = (r_state == ST_RESP);
    assign resp_err   = resp_valid && w_err;
    assign resp_rdata = (resp_valid && !r_we) ? w_rdata : '0;

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request accept to response (legal range 1..8).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present from memory stage.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-010 SHALL have port req_unsigned  input  1  zero-extend load when 1, sign-extend when 0.
REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-012 SHALL have port resp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port resp_rdata  output  32  extended load data; 0 for stores.
REQ-014 SHALL have port resp_err  output  1  access fault flag, valid with resp_valid.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, and SHALL capture addr, size, we, unsigned and wdata.
REQ-017 SHALL transition IDLE->RESP on accept when LATENCY = 1; otherwise IDLE->WAIT, holding WAIT for LATENCY-1 cycles via a down-counter.
REQ-018 SHALL assert resp_valid for exactly one cycle, in RESP, LATENCY cycles after the accept edge, then return to IDLE.
REQ-019 SHALL sustain at most one request per LATENCY+1 cycles; req_valid while not ready is ignored, with no queuing.
REQ-020 SHALL commit a store in the RESP cycle, writing only the byte lanes selected by req_size and addr[1:0].
REQ-021 SHALL index words with addr[log2(DEPTH_WORDS)+1:2], so higher address bits wrap modulo memory size.
REQ-022 SHALL shift a load's selected lane(s) to bit 0, then sign- or zero-extend to 32 bits.
REQ-023 SHALL return read data reflecting all stores committed before the load was accepted.
REQ-024 SHALL force resp_rdata = 0 when resp_valid = 0.

Reset
REQ-025 SHALL, on rst low, immediately force state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 0 while asserted.
REQ-026 SHALL abandon an in-flight request when reset occurs mid-operation, with no write committed and no response issued.
REQ-027 SHALL NOT reset memory contents; req_ready SHALL become 1 on the first edge after rst deasserts.

Configuration
REQ-028 SHALL, with DATA_MEMORY_ERR_EN defined, flag misalignment (half with addr[0]=1, word with addr[1:0]!=0) and req_size=11 as resp_err=1, with resp_rdata=0 and the store suppressed.
REQ-029 SHALL, without DATA_MEMORY_ERR_EN, tie resp_err to 0, align the address down to the access size, and treat size 11 as word.

Structure
REQ-030 SHALL place the access-size enum, the FSM state enum and the maximum-LATENCY constant in shared package dmem_pkg.
REQ-031 SHALL implement load extract/extend and store lane-merge in combinational sub-module dmem_lane_align.
REQ-032 SHALL infer storage as a synchronous single-port word array.

Verification
REQ-033 SHALL cover: word store 0xDEADBEEF to 0x40, then word load 0x40 -> resp_rdata 0xDEADBEEF, resp_valid exactly 2 cycles after each accept.
REQ-034 SHALL cover: byte load 0x43 signed after REQ-033 -> 0xFFFFFFDE; unsigned -> 0x000000DE; half load 0x40 signed -> 0xFFFFBEEF.
REQ-035 SHALL cover: byte store 0x11 to 0x41, then word load 0x40 -> 0xDEAD11EF.
REQ-036 SHALL cover: req_valid held high continuously -> req_ready low during WAIT/RESP, accepts exactly every 3 cycles at LATENCY=2.
REQ-037 SHALL cover: store accepted, rst pulsed low during WAIT -> no resp_valid, and a subsequent load returns the old data.
REQ-038 SHALL cover, with DATA_MEMORY_ERR_EN: word store to 0x42 -> resp_err=1, memory unchanged; without the macro -> data written at 0x40, resp_err=0.
